cache_axi_bridge: RTL and testbench
===================================

# cache_axi_bridge

Parametrised successor to the two-client cache/AXI bridge in the CPU top. It arbitrates `NUM_RD` cache refill read ports onto one AXI3 read channel and keeps one read outstanding per client, using `arid` = client index. It also drains one dirty-line write buffer as an AXI INCR burst and blocks reads that hit the buffered line until the write response arrives. It sits between the icache/dcache instances and the AXI master ports of `mycpu_top`.

## Interface
Parameters:
- `NUM_RD`, default 2: number of cache read clients, 1..16.
- `LINE_WORDS`, default 4: 32-bit words per cache line, power of 2, 2..16.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `rd_req` in NUM_RD: per-client read request.
- `rd_type` in 3*NUM_RD: per-client type; 000 byte, 001 half, 010 word, 100 line.
- `rd_addr` in 32*NUM_RD: per-client address; client i is at slice [32i+31:32i].
- `rd_rdy` out NUM_RD: request accepted this cycle.
- `ret_valid` out NUM_RD: return beat valid for client i.
- `ret_last` out NUM_RD: last beat for client i.
- `ret_data` out 32: shared return data.
- `wr_req` in 1: write request.
- `wr_type` in 3: write type, same encoding as `rd_type`.
- `wr_addr` in 32: write address.
- `wr_wstrb` in 4: byte strobe for single writes.
- `wr_data` in 32*LINE_WORDS: write data; word k is at slice [32k+31:32k].
- `wr_rdy` out 1: write buffer empty.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arvalid` out 4/32/8/3/2/1, and `arready` in 1: AXI read address channel.
- `arlock`/`arcache`/`arprot` out 2/4/3, and the same fields on AW: tied 0.
- `rid`/`rdata`/`rlast`/`rvalid` in 4/32/1/1, and `rready` out 1: AXI read data channel.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid` out 4/32/8/3/2/1, and `awready` in 1: AXI write address channel.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid` out 4/32/4/1/1, and `wready` in 1: AXI write data channel.
- `bid` in 4, `bvalid` in 1, `bready` out 1: AXI write response channel.

## Operation
- **Type mapping (read and write):**
  - Line type (100): len = LINE_WORDS-1, size = 2, burst = 01 (INCR), address passed through unaligned.
  - Other types: len = 0, size = type[1:0], burst = 01.
- **Read accept:**
  - Client i is eligible when `rd_req[i]`, `!pend[i]`, the AR register is empty, and there is no RAW hit.
  - The arbiter grants one eligible client per cycle; `rd_rdy[i]` is high only for the granted client.
  - On grant: load the AR register, set `arid` = i, set `pend[i]`.
- **Read return:**
  - `rready` is 1 whenever out of reset.
  - `ret_valid[rid]` = `rvalid`, `ret_last[rid]` = `rlast`, `ret_data` = `rdata`.
  - `pend[rid]` clears on `rvalid & rlast`.
  - If `rid` ≥ NUM_RD, the beat is consumed and dropped; no `ret_valid` is raised.
- **Write FSM states:** W_IDLE → W_AW → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `wr_rdy` = 1; on `wr_req`, capture the whole request and go to W_AW.
  - W_AW: `awvalid` = 1; on `awready`, go to W_DATA.
  - W_DATA: `wvalid` = 1, `wdata` = word[beat], `wstrb` = 4'hF for line writes else `wr_wstrb`. The beat counter increments on `wready`. `wlast` is high at beat = awlen. Go to W_RESP after the `wlast & wready` handshake.
  - W_RESP: `bready` = 1; on `bvalid`, return to W_IDLE.
  - `awid` = `wid` = 4'd1; `bid` is ignored.
- **RAW hazard:**
  - While the FSM is not in W_IDLE, a read whose `rd_addr[31:log2(4*LINE_WORDS)]` equals the buffered line address is ineligible.
  - Other reads proceed and overlap with the write.
- **Simultaneous events:**
  - A grant and an R beat for different clients in the same cycle are both handled.
  - A `bvalid` handshake and a new read of the same line in the same cycle: the read becomes eligible the next cycle.

## Timing
- Reset: all registered outputs are 0 and the FSM is in W_IDLE. This covers `arvalid`, `awvalid`, `wvalid`, `wlast`, `bready`, the `ar*`/`aw*` fields, and `pend`. `rready` = 0 during reset.
- `rd_rdy` and `wr_rdy` are combinational from state and inputs.
- `arvalid` rises the cycle after grant and holds stable until `arready`. A new grant is possible in the cycle after the AR handshake.
- `ret_*` is combinational from the R channel, with zero added latency.
- Write timing: `awvalid` 1 cycle after accept; `wvalid` 1 cycle after the AW handshake; one beat per `wready` cycle; `wr_rdy` high 1 cycle after the B handshake.
- A reset assertion mid-burst abandons all transactions; the AXI slave is reset together with the bridge.

## Configuration
- `CACHE_AXI_BRIDGE_RR_EN` defined:
  - Round-robin arbitration; a pointer gives highest priority to (last granted + 1) mod NUM_RD.
  - The pointer updates only on grant and resets to 0.
- Not defined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Client 0 line read at 0x1C000010, NUM_RD=2, LINE_WORDS=4 → `arid`=0, `arlen`=3, `arsize`=2, `arburst`=1. Four `ret_valid[0]` beats follow, `ret_last[0]` only on the 4th, and `pend[0]` clears afterwards.
- Both clients request in the same cycle, 4 times back to back:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: client 0 wins every cycle it requests, and a second request from client 0 is blocked until its return.
- Reads of both clients outstanding, slave returns `rid`=1 before `rid`=0 → data is routed to the correct `ret_valid` bits; `rid`=5 injected → no `ret_valid` raised.
- Line write to 0x00001000 with data words 0x11..0x44 → AW `awlen`=3, then W beats 0x11, 0x22, 0x33, 0x44 with `wstrb`=F and `wlast` on the 4th. With `wready` stalled for 2 cycles, `wdata` holds. `wr_rdy` returns 1 cycle after `bvalid`.
- Pending write to line 0x00001000, then a read of 0x00001008 → `rd_rdy` stays 0 until the B handshake. A concurrent read of 0x00002000 is accepted immediately.
- `aresetn` low for 1 cycle during the W_DATA beat 2 → all outputs are 0 and `wr_rdy` = 1 the next cycle.

Source files
------------

// File: rtl/cache_axi_bridge.sv
// Cache/AXI3 bridge: arbitrates NUM_RD cache refill reads onto one AR channel and drains one dirty-line write buffer.
// Optional macro CACHE_AXI_BRIDGE_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module cache_axi_bridge #(
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_RD-1:0]       rd_req,
    input  logic [3*NUM_RD-1:0]     rd_type,
    input  logic [32*NUM_RD-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_rdy,
    output logic [NUM_RD-1:0]       ret_valid,
    output logic [NUM_RD-1:0]       ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int unsigned OFF_W  = $clog2(4 * LINE_WORDS);
    localparam int unsigned IDX_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam logic [2:0]  TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    wstate_t                         wstate;
    logic [31-OFF_W:0]               wline;
    logic [LINE_WORDS-1:0][31:0]     wbuf;
    logic [BEAT_W-1:0]               beat;
    logic [BEAT_W-1:0]               beat_nxt;
    logic [NUM_RD-1:0]               pend;
    logic [NUM_RD-1:0]               pend_nxt;
    logic [NUM_RD-1:0]               raw_hit;
    logic [NUM_RD-1:0]               elig;
    logic                            gnt_vld;
    logic [IDX_W-1:0]                gnt_idx;
    logic [31:0]                     gnt_addr;
    logic [2:0]                      gnt_type;
    logic                            wr_line;
    logic                            unused_bid;

    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awid    = 4'd1;
    assign wid     = 4'd1;
    assign unused_bid = ^bid;

    assign wr_rdy   = (wstate == W_IDLE);
    assign ret_data = rdata;
    assign wr_line  = (wr_type == TYPE_LINE);
    assign beat_nxt = beat + BEAT_W'(1);

    // Reads to the line held in the write buffer wait until the write response.
    always_comb begin
        raw_hit = '0;
        elig    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            raw_hit[i] = (wstate != W_IDLE) && (rd_addr[32*i+OFF_W +: 32-OFF_W] == wline);
            elig[i]    = rd_req[i] && !pend[i] && !arvalid && !raw_hit[i];
        end
    end

`ifdef CACHE_AXI_BRIDGE_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_RD));
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_RD - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Grant decode, request mux, return routing and pending bookkeeping.
    always_comb begin
        gnt_addr  = '0;
        gnt_type  = '0;
        rd_rdy    = '0;
        ret_valid = '0;
        ret_last  = '0;
        pend_nxt  = pend;
        for (int i = 0; i < NUM_RD; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_addr = rd_addr[32*i +: 32];
                gnt_type = rd_type[3*i +: 3];
            end
            rd_rdy[i]    = gnt_vld && (gnt_idx == IDX_W'(i));
            ret_valid[i] = rvalid && (rid == 4'(i));
            ret_last[i]  = ret_valid[i] && rlast;
            if (ret_last[i]) pend_nxt[i] = 1'b0;
            if (rd_rdy[i])   pend_nxt[i] = 1'b1;
        end
    end

    // AR register and read-side state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arburst <= '0;
            pend    <= '0;
            rready  <= 1'b0;
        end else begin
            rready <= 1'b1;
            pend   <= pend_nxt;
            if (gnt_vld) begin
                arvalid <= 1'b1;
                arid    <= 4'(gnt_idx);
                araddr  <= gnt_addr;
                arlen   <= (gnt_type == TYPE_LINE) ? 8'(LINE_WORDS - 1) : 8'd0;
                arsize  <= (gnt_type == TYPE_LINE) ? 3'd2 : {1'b0, gnt_type[1:0]};
                arburst <= 2'b01;
            end else if (arready) begin
                arvalid <= 1'b0;
            end
        end
    end

    // Write buffer drain FSM.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wlast   <= 1'b0;
            bready  <= 1'b0;
            wbuf    <= '0;
            wline   <= '0;
            beat    <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (wr_req) begin
                    wstate  <= W_AW;
                    awvalid <= 1'b1;
                    awaddr  <= wr_addr;
                    awlen   <= wr_line ? 8'(LINE_WORDS - 1) : 8'd0;
                    awsize  <= wr_line ? 3'd2 : {1'b0, wr_type[1:0]};
                    awburst <= 2'b01;
                    wstrb   <= wr_line ? 4'hF : wr_wstrb;
                    wbuf    <= wr_data;
                    wline   <= wr_addr[31:OFF_W];
                    beat    <= '0;
                end
                W_AW: if (awready) begin
                    wstate  <= W_DATA;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    wdata   <= wbuf[0];
                    wlast   <= (awlen == 8'd0);
                end
                W_DATA: if (wready) begin
                    if (wlast) begin
                        wstate <= W_RESP;
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                        bready <= 1'b1;
                    end else begin
                        beat  <= beat_nxt;
                        wdata <= wbuf[beat_nxt];
                        wlast <= (8'(beat_nxt) == awlen);
                    end
                end
                W_RESP: if (bvalid) begin
                    wstate <= W_IDLE;
                    bready <= 1'b0;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge (NUM_RD=2, LINE_WORDS=4); expectations adapt to CACHE_AXI_BRIDGE_RR_EN.
module tb_cache_axi_bridge;
    logic         aclk;
    logic         aresetn;
    logic [1:0]   rd_req;
    logic [5:0]   rd_type;
    logic [63:0]  rd_addr;
    logic [1:0]   rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid, arcache, awid, awcache, wid, wstrb, rid, bid;
    logic [31:0]  araddr, awaddr, wdata, rdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, arprot, awsize, awprot;
    logic [1:0]   arburst, arlock, awburst, awlock;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;
    int gid;

    cache_axi_bridge #(.NUM_RD(2), .LINE_WORDS(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rbeat(input logic [3:0] id, input logic [31:0] data, input logic last);
        rvalid = 1'b1; rid = id; rdata = data; rlast = last;
    endtask

    initial begin
        aclk = 1'b0; aresetn = 1'b0;
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bvalid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid",  64'(wvalid),  64'd0);
        check("rst_bready",  64'(bready),  64'd0);
        check("rst_rready",  64'(rready),  64'd0);
        check("rst_wr_rdy",  64'(wr_rdy),  64'd1);
        aresetn = 1'b1;
        tick();
        check("rready_up", 64'(rready), 64'd1);

        // Client 0 line read
        rd_req = 2'b01; rd_type = {3'b000, 3'b100}; rd_addr = {32'h0, 32'h1C000010};
        #1 check("t1_rd_rdy", 64'(rd_rdy), 64'h1);
        tick();
        rd_req = 2'b00;
        check("t1_arvalid", 64'(arvalid), 64'd1);
        check("t1_arid",    64'(arid),    64'd0);
        check("t1_araddr",  64'(araddr),  64'h1C000010);
        check("t1_arlen",   64'(arlen),   64'd3);
        check("t1_arsize",  64'(arsize),  64'd2);
        check("t1_arburst", 64'(arburst), 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("t1_ar_done", 64'(arvalid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            rbeat(4'd0, 32'hA0 + 32'(b), b == 3);
            #1;
            check("t1_ret_valid", 64'(ret_valid), 64'h1);
            check("t1_ret_last",  64'(ret_last),  (b == 3) ? 64'h1 : 64'h0);
            check("t1_ret_data",  64'(ret_data),  64'hA0 + 64'(b));
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        rd_req = 2'b01;
        #1 check("t1_pend_clear", 64'(rd_rdy), 64'h1);
        rd_req = 2'b00;

        // Client 0 blocked while pending; out-of-order returns; foreign rid dropped
        rd_type = {3'b001, 3'b010}; rd_addr = {32'h200, 32'h100};
        rd_req = 2'b01;
        #1 check("t2_gnt0", 64'(rd_rdy), 64'h1);
        tick();
        rd_req = 2'b11;
        #1 check("t2_ar_busy", 64'(rd_rdy), 64'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1 check("t2_c0_blocked", 64'(rd_rdy), 64'h2);
        tick();
        rd_req = 2'b00;
        check("t2_arid",   64'(arid),   64'd1);
        check("t2_araddr", 64'(araddr), 64'h200);
        check("t2_arlen",  64'(arlen),  64'd0);
        check("t2_arsize", 64'(arsize), 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rd_req = 2'b11;
        #1 check("t2_both_pend", 64'(rd_rdy), 64'h0);
        rd_req = 2'b00;
        rbeat(4'd1, 32'hBEEF0001, 1'b1);
        #1;
        check("t2_rid1_valid", 64'(ret_valid), 64'h2);
        check("t2_rid1_last",  64'(ret_last),  64'h2);
        check("t2_rid1_data",  64'(ret_data),  64'hBEEF0001);
        tick();
        rbeat(4'd0, 32'hBEEF0000, 1'b1);
        #1 check("t2_rid0_valid", 64'(ret_valid), 64'h1);
        tick();
        rbeat(4'd5, 32'hDEAD0005, 1'b1);
        #1;
        check("t2_rid5_valid", 64'(ret_valid), 64'h0);
        check("t2_rid5_last",  64'(ret_last),  64'h0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Both clients request together, four rounds
        for (int r = 0; r < 4; r++) begin
`ifdef CACHE_AXI_BRIDGE_RR_EN
            gid = r % 2;
`else
            gid = 0;
`endif
            rd_req = 2'b11;
            #1 check("t3_rd_rdy", 64'(rd_rdy), 64'(2'b01 << gid));
            tick();
            rd_req = 2'b00;
            check("t3_arid", 64'(arid), 64'(gid));
            arready = 1'b1;
            tick();
            arready = 1'b0;
            rbeat(4'(gid), 32'h0, 1'b1);
            tick();
            rvalid = 1'b0; rlast = 1'b0;
        end

        // Line write with RAW blocking and an overlapping unrelated read
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00001000; wr_wstrb = 4'h0;
        wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
        #1 check("t4_wr_rdy_idle", 64'(wr_rdy), 64'd1);
        tick();
        wr_req = 1'b0;
        check("t4_wr_rdy_busy", 64'(wr_rdy),  64'd0);
        check("t4_awvalid",     64'(awvalid), 64'd1);
        check("t4_awaddr",      64'(awaddr),  64'h1000);
        check("t4_awlen",       64'(awlen),   64'd3);
        check("t4_awsize",      64'(awsize),  64'd2);
        check("t4_awburst",     64'(awburst), 64'd1);
        check("t4_awid",        64'(awid),    64'd1);
        rd_type = {3'b010, 3'b010}; rd_addr = {32'h00002000, 32'h00001008};
        rd_req = 2'b11;
        #1 check("t4_raw_split", 64'(rd_rdy), 64'h2);
        tick();
        rd_req = 2'b01;
        check("t4_arid",   64'(arid),   64'd1);
        check("t4_araddr", 64'(araddr), 64'h2000);
        arready = 1'b1; awready = 1'b1;
        tick();
        arready = 1'b0; awready = 1'b0;
        check("t4_wvalid", 64'(wvalid), 64'd1);
        check("t4_wdata0", 64'(wdata),  64'h11);
        check("t4_wstrb",  64'(wstrb),  64'hF);
        check("t4_wlast0", 64'(wlast),  64'd0);
        #1 check("t4_raw_blk", 64'(rd_rdy), 64'h0);
        for (int s = 0; s < 2; s++) begin
            tick();
            check("t4_stall_wdata",  64'(wdata),  64'h11);
            check("t4_stall_wvalid", 64'(wvalid), 64'd1);
        end
        wready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("t4_wdata", 64'(wdata), 64'h11 * 64'(k + 1));
            check("t4_wlast", 64'(wlast), (k == 3) ? 64'd1 : 64'd0);
        end
        tick();
        wready = 1'b0;
        check("t4_wvalid_off", 64'(wvalid), 64'd0);
        check("t4_bready",     64'(bready), 64'd1);
        #1 check("t4_raw_resp", 64'(rd_rdy), 64'h0);
        rbeat(4'd1, 32'h0, 1'b1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        bvalid = 1'b1;
        #1;
        check("t4_raw_bcyc", 64'(rd_rdy), 64'h0);
        check("t4_wr_rdy_b", 64'(wr_rdy), 64'd0);
        tick();
        bvalid = 1'b0;
        #1;
        check("t4_wr_rdy_after", 64'(wr_rdy), 64'd1);
        check("t4_bready_off",   64'(bready), 64'd0);
        check("t4_raw_release",  64'(rd_rdy), 64'h1);
        tick();
        rd_req = 2'b00;
        check("t4_rd_arid",   64'(arid),   64'd0);
        check("t4_rd_araddr", 64'(araddr), 64'h1008);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rbeat(4'd0, 32'h0, 1'b1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Reset in the middle of a write burst
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00003000;
        wr_data = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        tick();
        wr_req = 1'b0; awready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b1;
        tick();
        tick();
        wready = 1'b0;
        check("t5_wdata2",  64'(wdata),  64'hC3);
        check("t5_wvalid2", 64'(wvalid), 64'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("t5_awvalid", 64'(awvalid), 64'd0);
        check("t5_wvalid",  64'(wvalid),  64'd0);
        check("t5_wlast",   64'(wlast),   64'd0);
        check("t5_wdata",   64'(wdata),   64'd0);
        check("t5_bready",  64'(bready),  64'd0);
        check("t5_arvalid", 64'(arvalid), 64'd0);
        check("t5_awaddr",  64'(awaddr),  64'd0);
        check("t5_rready",  64'(rready),  64'd0);
        check("t5_wr_rdy",  64'(wr_rdy),  64'd1);
        tick();
        check("t5_rready_up", 64'(rready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
